// File: rtl/calc_pkg.sv
// calc_pkg: constants shared by seq_calc, its iteration step, the board-level
// controller and the testbench.
//   OP_*  : 2-bit opcodes presented on op_sel
//   ST_*  : FSM state encodings, plus the enum built from them
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // True when an accepted opcode completes without iterating:
  // add, sub, and divide by zero.
  function automatic logic op_is_fast(input logic [1:0] op, input logic divisor_zero);
    return (op == OP_ADD) || (op == OP_SUB) || ((op == OP_DIV) && divisor_zero);
  endfunction

endpackage

// File: rtl/seq_calc_iter.sv
// seq_calc_iter: one iteration of the multi-cycle datapath (purely combinational).
//   i_op    : latched opcode; OP_DIV selects the divide step, anything else multiply
//   i_acc   : current accumulator, 2*WIDTH+1 bits
//   i_mcand : multiplicand (latched x)
//   i_dvsr  : divisor (latched y)
//   o_acc   : accumulator after this step
//
// Multiply layout: {carry, hi[WIDTH], lo[WIDTH]}. lo starts as the multiplier;
// each step adds the multiplicand into hi when lo[0] is set, then shifts the
// whole thing right so the partial-sum carry lands in the top of hi.
//
// Divide layout: {rem[WIDTH+1], quo[WIDTH]}. quo starts as the dividend. Each
// step shifts {rem, quo} left by one, trial-subtracts the divisor from the
// remainder and keeps the old value (restore) if the trial goes negative.
module seq_calc_iter
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]         i_op,
  input  logic [2*WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_dvsr,
  output logic [2*WIDTH:0]   o_acc
);

  logic [WIDTH:0]   w_psum;
  logic [WIDTH+1:0] w_trial;

  // The shifted remainder is {rem, quo msb}; it stays below 2*divisor, so
  // WIDTH+2 bits are enough for the borrow in the top bit to mean "negative".
  assign w_psum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_mcand} : '0);
  assign w_trial = {i_acc[2*WIDTH:WIDTH], i_acc[WIDTH-1]} - {2'b00, i_dvsr};

  always_comb begin
    o_acc = i_acc;
    if (i_op == OP_DIV) begin
      if (w_trial[WIDTH+1]) o_acc = {i_acc[2*WIDTH-1:0], 1'b0};
      else                  o_acc = {w_trial[WIDTH:0], i_acc[WIDTH-2:0], 1'b1};
    end else begin
      o_acc = {1'b0, w_psum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/seq_calc.sv
// seq_calc: multi-cycle add/sub/mul/div unit with a start/done handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, sampled only while busy is low
//   x, y        : operands (dividend/multiplicand, divisor/multiplier)
//   op_sel      : OP_ADD / OP_SUB / OP_MUL / OP_DIV
//   busy        : high in RUN and DONE
//   done        : one-cycle pulse, result/flags valid from here on
//   result      : 2*WIDTH-bit result, held until the next completion
//   carry_out   : add/sub carry (sub: 1 = no borrow)
//   overflow    : add/sub signed overflow
//   div_by_zero : divide with y == 0
// Add, sub and divide-by-zero finish straight from IDLE; mul/div spend WIDTH
// cycles in RUN, one bit per cycle, via seq_calc_iter.
module seq_calc
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [1:0]         op_sel,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_out,
  output logic               overflow,
  output logic               div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e             r_state, w_next_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH:0]   r_acc;
  logic [2*WIDTH:0]   w_iter_acc;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_mcand, r_dvsr;
  logic [2*WIDTH-1:0] r_result;
  logic               r_carry, r_ovf, r_dbz, r_busy, r_done;

  logic               w_accept, w_y_zero, w_is_sub, w_ovf, w_last;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH:0]     w_sum;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_y_zero = (y == '0);
  assign w_last   = (r_cnt == CNT_LAST);

  // Add/sub straight off the inputs: sub is x + ~y + 1.
  assign w_is_sub = (op_sel == OP_SUB);
  assign w_b      = w_is_sub ? ~y : y;
  assign w_sum    = {1'b0, x} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_ovf    = (x[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != x[WIDTH-1]);

  seq_calc_iter #(.WIDTH(WIDTH)) u_iter (
    .i_op    (r_op),
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_dvsr  (r_dvsr),
    .o_acc   (w_iter_acc)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start) w_next_state = op_is_fast(op_sel, w_y_zero) ? S_DONE : S_RUN;
      S_RUN:  if (w_last) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_op     <= OP_ADD;
      r_mcand  <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_dbz    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // busy/done are registered copies of the next-state decode.
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= (w_next_state == S_DONE);

      if (w_accept) begin
        r_op    <= op_sel;
        r_mcand <= x;
        r_dvsr  <= y;
        r_cnt   <= '0;
        r_acc   <= {1'b0, {WIDTH{1'b0}}, (op_sel == OP_MUL) ? y : x};
        case (op_sel)
          OP_ADD, OP_SUB: begin
            r_result <= {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
            r_carry  <= w_sum[WIDTH];
            r_ovf    <= w_ovf;
            r_dbz    <= 1'b0;
          end
          OP_DIV: begin
            if (w_y_zero) begin
              r_result <= {x, {WIDTH{1'b1}}};
              r_carry  <= 1'b0;
              r_ovf    <= 1'b0;
              r_dbz    <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (r_state == S_RUN) begin
        r_acc <= w_iter_acc;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_result <= w_iter_acc[2*WIDTH-1:0];
          r_carry  <= 1'b0;
          r_ovf    <= 1'b0;
          r_dbz    <= 1'b0;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign carry_out   = r_carry;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_calc.sv
module tb_seq_calc;
  import calc_pkg::*;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   x = '0, y = '0;
  logic [1:0]     op_sel = OP_ADD;
  logic           busy, done, carry_out, overflow, div_by_zero;
  logic [2*W-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  seq_calc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .op_sel(op_sel),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [7:0]  a, b;
    logic [15:0] r;
    logic [2:0]  fl;   // {carry, overflow, div_by_zero}
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model from the arithmetic definitions.
  task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] r, output logic [2:0] fl, output int lat);
    int ua, ub, sa, sb, s;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    fl = 3'b000; lat = 1;
    case (op)
      OP_ADD: begin
        s = ua + ub; r = 16'(s & 255);
        fl = {s > 255, (sa + sb > 127) || (sa + sb < -128), 1'b0};
      end
      OP_SUB: begin
        s = ua - ub; r = 16'(s & 255);
        fl = {ua >= ub, (sa - sb > 127) || (sa - sb < -128), 1'b0};
      end
      OP_MUL: begin r = 16'(ua * ub); lat = W + 1; end
      default: begin
        if (ub == 0) begin r = {a, 8'hFF}; fl = 3'b001; end
        else begin r = 16'(((ua % ub) << 8) | (ua / ub)); lat = W + 1; end
      end
    endcase
  endtask

  // Issue one op, then watch W+4 cycles: latency, result, flags, busy shape,
  // single done, and result/flags held after done.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] er, input logic [2:0] ef,
                        input int el);
    int lat = -1, nd = 0;
    logic [15:0] res = '0;
    logic [2:0]  fl = '0;
    bit bok = 1'b1, hok = 1'b1;
    @(negedge clk);
    start = 1'b1; op_sel = op; x = a; y = b;
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'(k <= el)) bok = 1'b0;
      if (done === 1'b1) begin
        nd++;
        if (lat < 0) begin lat = k; res = result; fl = {carry_out, overflow, div_by_zero}; end
      end else if (lat > 0 && (result !== res || {carry_out, overflow, div_by_zero} !== fl)) begin
        hok = 1'b0;
      end
    end
    chk({nm, "_latency"}, lat, el);
    chk({nm, "_ndone"}, nd, 1);
    chk({nm, "_result"}, {16'h0, res}, {16'h0, er});
    chk({nm, "_flags"}, {29'h0, fl}, {29'h0, ef});
    chk({nm, "_busy_hold"}, {30'h0, bok, hok}, 32'h3);
  endtask

  vec_t vt[$];

  initial begin
    logic [15:0] er;
    logic [2:0]  ef;
    int el, nd, lat;
    logic [1:0] rop;
    logic [7:0] ra, rb;

    vt.push_back('{"add_200_100", OP_ADD, 8'd200, 8'd100, 16'h002C, 3'b100, 1});
    vt.push_back('{"sub_80_01",   OP_SUB, 8'h80,  8'h01,  16'h007F, 3'b110, 1});
    vt.push_back('{"sub_3_5",     OP_SUB, 8'd3,   8'd5,   16'h00FE, 3'b000, 1});
    vt.push_back('{"add_127_1",   OP_ADD, 8'd127, 8'd1,   16'h0080, 3'b010, 1});
    vt.push_back('{"sub_0_0",     OP_SUB, 8'd0,   8'd0,   16'h0000, 3'b100, 1});
    vt.push_back('{"mul_ff_ff",   OP_MUL, 8'd255, 8'd255, 16'hFE01, 3'b000, 9});
    vt.push_back('{"mul_0_77",    OP_MUL, 8'd0,   8'd77,  16'h0000, 3'b000, 9});
    vt.push_back('{"mul_1_ff",    OP_MUL, 8'd1,   8'd255, 16'h00FF, 3'b000, 9});
    vt.push_back('{"div_200_7",   OP_DIV, 8'd200, 8'd7,   16'h041C, 3'b000, 9});
    vt.push_back('{"div_7_200",   OP_DIV, 8'd7,   8'd200, 16'h0700, 3'b000, 9});
    vt.push_back('{"div_ff_1",    OP_DIV, 8'd255, 8'd1,   16'h00FF, 3'b000, 9});
    vt.push_back('{"div_55_0",    OP_DIV, 8'h55,  8'h00,  16'h55FF, 3'b001, 1});

    // Reset state.
    #2;
    chk("reset_outputs", {11'h0, busy, done, result, carry_out, overflow, div_by_zero}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) run_op(vt[i].nm, vt[i].op, vt[i].a, vt[i].b, vt[i].r, vt[i].fl, vt[i].lat);

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      model(rop, ra, rb, er, ef, el);
      run_op($sformatf("rnd%0d_op%0d_%0h_%0h", i, rop, ra, rb), rop, ra, rb, er, ef, el);
    end

    // Start pulses in cycles 3 and 9 of a mul must be ignored.
    @(negedge clk);
    start = 1'b1; op_sel = OP_MUL; x = 8'd255; y = 8'd3;
    nd = 0; lat = -1;
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin nd++; lat = k; end
      if (k == 3 || k == 9) begin start = 1'b1; op_sel = OP_ADD; x = 8'd1; y = 8'd1; end
      else start = 1'b0;
    end
    chk("ignore_ndone", nd, 1);
    chk("ignore_latency", lat, 9);
    chk("ignore_result", {16'h0, result}, 32'd765);

    // start held high: back-to-back adds complete every other cycle.
    @(negedge clk);
    start = 1'b1; op_sel = OP_ADD; x = 8'd1; y = 8'd2;
    nd = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    start = 1'b0;
    chk("b2b_ndone", nd, 3);
    chk("b2b_result", {16'h0, result}, 32'd3);
    @(negedge clk); @(negedge clk);

    // Reset in cycle 4 of a mul.
    @(negedge clk);
    start = 1'b1; op_sel = OP_MUL; x = 8'd255; y = 8'd255;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {11'h0, busy, done, result, carry_out, overflow, div_by_zero}, 32'h0);
    @(negedge clk);
    chk("midreset_held", {30'h0, busy, done}, 32'h0);
    rst_n = 1'b1;
    run_op("after_reset_add", OP_ADD, 8'd1, 8'd1, 16'h0002, 3'b000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
